// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: debounces run/step buttons and issues a one-cycle CPU clock enable,
// either once per step press (PAUSE) or every RUN_DIV cycles (RUN).
module cpu_step_ctrl #(
   parameter int RUN_DIV     = 100_000_000,
   parameter int DB_CYCLES   = 1_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_run,
   input  logic       btn_step,
   output logic       cpu_ce,
   output logic       running,
   output logic [7:0] tick_cnt
);
   localparam int DW = $clog2(DB_CYCLES);
   localparam int RW = $clog2(RUN_DIV);
   localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES - 1);
   localparam logic [RW-1:0] DIV_MAX = RW'(RUN_DIV - 1);
   logic [1:0]                  btn;
   logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0][DW-1:0]          cnt_q, cnt_d;
   logic [1:0]                  stable_q, stable_d, prev_q, press;
   logic [RW-1:0]               div_q, div_d;
   logic                        running_q, running_d, cpu_ce_q, cpu_ce_d;
   logic [7:0]                  tick_q, tick_d;
   logic                        run_press, step_press;
   assign btn        = {btn_step, btn_run};
   assign press      = stable_q & ~prev_q;
   assign run_press  = press[0];
   assign step_press = press[1];
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         sync_d[b]   = {sync_q[b][SYNC_STAGES-2:0], btn[b]};
         stable_d[b] = stable_q[b];
         cnt_d[b]    = '0;
         if (sync_q[b][SYNC_STAGES-1] != stable_q[b]) begin
            if (cnt_q[b] == DB_MAX) stable_d[b] = sync_q[b][SYNC_STAGES-1];
            else cnt_d[b] = cnt_q[b] + 1'b1;
         end
      end
   end
   // A run toggle always wins: it clears the divider and swallows any step or periodic pulse.
   always_comb begin
      running_d = running_q ^ run_press;
      div_d     = (run_press || !running_q || div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      cpu_ce_d  = !run_press && (running_q ? div_q == DIV_MAX : step_press);
      tick_d    = tick_q + {7'd0, cpu_ce_q};
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         stable_q  <= '0;
         prev_q    <= '0;
         div_q     <= '0;
         running_q <= 1'b0;
         cpu_ce_q  <= 1'b0;
         tick_q    <= '0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         stable_q  <= stable_d;
         prev_q    <= stable_q;
         div_q     <= div_d;
         running_q <= running_d;
         cpu_ce_q  <= cpu_ce_d;
         tick_q    <= tick_d;
      end
   end
   assign cpu_ce   = cpu_ce_q;
   assign running  = running_q;
   assign tick_cnt = tick_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: directed and random button stimulus checked every cycle against
// a window-based behavioural model of debounce, mode toggling and pulse timing.
module tb_cpu_step_ctrl;
   localparam int RUN_DIV     = 10;
   localparam int DB_CYCLES   = 4;
   localparam int SYNC_STAGES = 2;
   localparam int HLEN        = SYNC_STAGES + DB_CYCLES;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       btn_run = 1'b0;
   logic       btn_step = 1'b0;
   logic       cpu_ce, running;
   logic [7:0] tick_cnt;
   int         n_tests = 0;
   int         n_fail = 0;
   int         ce_seen = 0;
   always #5 clk = ~clk;
   cpu_step_ctrl #(.RUN_DIV(RUN_DIV), .DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk), .reset_n(reset_n), .btn_run(btn_run), .btn_step(btn_step),
      .cpu_ce(cpu_ce), .running(running), .tick_cnt(tick_cnt)
   );
   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   // Reference model: raw button history; the debounced level flips once the last
   // DB_CYCLES synchronized samples all disagree with it.
   bit         hr[$], hs[$];
   bit         st_r, st_s, p_run, p_step, m_run, m_ce, ce_new;
   int         m_cnt;
   logic [7:0] m_tick;
   function automatic bit flips(input bit q[$], input bit st);
      for (int j = 0; j < DB_CYCLES; j++) if (q[j] == st) return 1'b0;
      return 1'b1;
   endfunction
   always @(negedge clk) begin
      if (!reset_n) begin
         hr = {};
         hs = {};
         for (int i = 0; i < HLEN - 1; i++) begin
            hr.push_back(1'b0);
            hs.push_back(1'b0);
         end
         {st_r, st_s, p_run, p_step, m_run, m_ce} = '0;
         m_cnt  = 0;
         m_tick = '0;
      end else begin
         ce_new = 1'b0;
         if (p_run) begin
            m_run = !m_run;
            m_cnt = 0;
         end else if (m_run) begin
            m_cnt++;
            ce_new = (m_cnt % RUN_DIV) == 0;
         end else ce_new = p_step;
         m_tick = m_tick + 8'(m_ce);
         m_ce   = ce_new;
         hr.push_back(btn_run);
         hs.push_back(btn_step);
         if (hr.size() > HLEN) begin
            void'(hr.pop_front());
            void'(hs.pop_front());
         end
         p_run  = 1'b0;
         p_step = 1'b0;
         if (flips(hr, st_r)) begin
            st_r  = !st_r;
            p_run = st_r;
         end
         if (flips(hs, st_s)) begin
            st_s   = !st_s;
            p_step = st_s;
         end
         if (cpu_ce) ce_seen++;
      end
      check("cpu_ce", cpu_ce, m_ce);
      check("running", running, m_run);
      check("tick_cnt", tick_cnt, m_tick);
   end
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask
   initial begin
      int s, lat, n, first;
      int pos[3];
      cyc(3);
      reset_n = 1'b1;
      cyc(50);
      check("t1_no_ce", ce_seen, 0);
      check("t1_tick", tick_cnt, 0);
      btn_step = 1'b1;
      cyc(3);
      btn_step = 1'b0;
      cyc(20);
      check("t2_glitch_no_ce", ce_seen, 0);
      check("t2_tick", tick_cnt, 0);
      s = ce_seen;
      lat = 0;
      btn_step = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cyc(1);
         if (cpu_ce && lat == 0) lat = i;
      end
      btn_step = 1'b0;
      cyc(10);
      check("t3_one_pulse", ce_seen - s, 1);
      check("t3_tick", tick_cnt, 1);
      check("t3_latency_ok", (lat >= SYNC_STAGES + DB_CYCLES && lat <= SYNC_STAGES + DB_CYCLES + 2) ? 1 : 0, 1);
      btn_run = 1'b1;
      for (int i = 0; i < 30 && !running; i++) cyc(1);
      check("t4_running", running, 1);
      btn_run = 1'b0;
      n = 0;
      for (int i = 1; i <= 35; i++) begin
         if (i == 12) btn_step = 1'b1;
         if (i == 20) btn_step = 1'b0;
         cyc(1);
         if (cpu_ce) begin
            if (n < 3) pos[n] = i;
            n++;
         end
      end
      check("t4_pulse_count", n, 3);
      check("t4_pulse1", pos[0], 10);
      check("t4_pulse2", pos[1], 20);
      check("t4_pulse3", pos[2], 30);
      btn_run = 1'b1;
      for (int i = 0; i < 30 && running; i++) cyc(1);
      check("t4_paused", running, 0);
      btn_run = 1'b0;
      s = ce_seen;
      cyc(30);
      check("t4_pulses_stop", ce_seen - s, 0);
      btn_run  = 1'b1;
      btn_step = 1'b1;
      for (int i = 0; i < 30 && !running; i++) cyc(1);
      check("t5_running", running, 1);
      check("t5_no_step_pulse", cpu_ce, 0);
      btn_run  = 1'b0;
      btn_step = 1'b0;
      first = 0;
      for (int i = 1; i <= 20 && first == 0; i++) begin
         cyc(1);
         if (cpu_ce) first = i;
      end
      check("t5_first_pulse", first, 10);
      for (int k = 0; k < 150; k++) begin
         btn_run  = ($urandom_range(0, 7) == 0);
         btn_step = $urandom_range(0, 1);
         cyc($urandom_range(1, 12));
      end
      btn_run  = 1'b0;
      btn_step = 1'b0;
      cyc(20);
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      btn_run = 1'b1;
      for (int i = 0; i < 30 && !running; i++) cyc(1);
      check("t6_running", running, 1);
      btn_run = 1'b0;
      s = ce_seen;
      cyc(2561);
      check("t6_256_pulses", ce_seen - s, 256);
      check("t6_tick_wrap", tick_cnt, 0);
      cyc(6);
      reset_n = 1'b0;
      #1;
      check("t6_rst_ce", cpu_ce, 0);
      check("t6_rst_running", running, 0);
      check("t6_rst_tick", tick_cnt, 0);
      s = ce_seen;
      cyc(5);
      reset_n = 1'b1;
      cyc(20);
      check("t6_no_pulse_after_rst", ce_seen - s, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
